cpu_mc_param: RTL and testbench
===============================

// Module: cpu_mc_param
// PURPOSE
//  Parametrised multi-cycle CPU with the existing 10-opcode ISA (NOP LD STR BRA XOR ADD ROT SHF HLT CMP).
//  Adds a mem_en/mem_ack handshake so memory may insert wait states.
//  Adds a registered PSR, a HALT state and configurable data/address/register-file sizes.
//  Sits between the memory model and the testbench top.
// PARAMETERS
//  DATA_W  32  datapath and register width; >=32, instruction word is data_in[31:0]
//  ADDR_W  12  memory address width, 4..12; address fields use their low ADDR_W bits
//  NREG    16  register count, power of two, 2..16; register index = low $clog2(NREG) bits of a 4-bit field
// PORTS
//  clk_in      in   1       clock, all state updates on rising edge
//  reset       in   1       synchronous, active-high
//  data_in     in   DATA_W  read data / instruction from memory
//  mem_ack     in   1       memory completes current request this cycle
//  data_out    out  DATA_W  store data to memory
//  address     out  ADDR_W  memory address
//  read_write  out  1       0 = read, 1 = write
//  mem_en      out  1       request valid
//  halted      out  1       CPU is in HALT state
//  psr         out  5       {Z,N,E,P,C} registered flags
//  retired_cnt out  32      instructions retired (present only with CPU_PERF_CNT_EN)
// BEHAVIOUR
//  Reset (sync): state=FETCH, PC=0, IR=0, regs=0, psr=0, mem_en=0, read_write=0, address=0, data_out=0, halted=0.
//  Format: [31:28] op; [27] src-imm; [26] dst-zero; [27:24] BRA cond; [23:12] src/imm/mem-src; [15:12] src reg; [11:0] dst.
//   [11:0] holds the mem-dst for STR and the branch target for BRA; [3:0] holds the dst reg.
//  Operands:
//   op1 = [27] ? zero-extended [23:12] : R[[15:12]].
//   op2 = [26] ? 0 : R[[3:0]].
//  FSM states and timing:
//   FETCH  - issues a read at PC and latches IR on ack.
//   DECODE - 1 cycle.
//   EXEC   - 1 cycle.
//   MEM    - LD/STR only; waits for ack.
//   WB     - 1 cycle.
//   HALT   - terminal.
//  Latency, zero-wait memory: 4 cycles for ALU/BRA/NOP; 5 cycles for LD/STR.
//  Handshake:
//   mem_en, address, read_write and data_out are held stable until mem_ack=1 is sampled.
//   mem_en drops the cycle after ack.
//   Same-cycle ack is legal.
//   mem_ack while mem_en=0 is ignored.
//  LD: read at [23:12]; data_in latched on ack; written to R[[3:0]] in WB.
//  STR: write op1 to [11:0].
//  ALU ops:
//   XOR = op1^op2.
//   ADD = {C,res} = op1+op2.
//   CMP = -op1 (two's complement), C=0.
//   Undefined opcodes behave as NOP.
//  SHF/ROT: CW=$clog2(DATA_W); count=op1[CW-1:0]; op1[CW]=1 means left. Operand is op2.
//   SHF left: C = last bit shifted out.
//   SHF right: C = 0.
//   ROT: C = 0.
//   count 0: result = op2.
//  PSR:
//   Updated in WB only for XOR/ADD/ROT/SHF/CMP; unchanged otherwise.
//   Z = res==0; N = res[DATA_W-1]; P = ^res; E = ~P.
//  BRA cond, from registered PSR at EXEC:
//   0 always; 1 P; 2 E; 3 C; 4 N; 5 Z; 6 ~C; 7 ~N&~Z; 8-15 never.
//   Taken: PC <= [11:0]. Otherwise PC <= PC+1.
//  PC wraps from 2^ADDR_W-1 to 0.
//  HLT: enter HALT in WB; halted=1, mem_en=0; stays until reset.
//  Reset mid-request: state=FETCH and mem_en=0 next cycle; the pending ack is ignored.
// CONFIGURATION
//  CPU_PERF_CNT_EN defined:
//   retired_cnt resets to 0 and increments once per instruction leaving WB, including HLT.
//   It wraps at 2^32.
//  CPU_PERF_CNT_EN undefined: port and counter are absent; all other behaviour is identical.
// STRUCTURE
//  cpu_pkg:
//   opcode localparams, BRA condition codes, FSM state encoding, PSR bit indices (Z=4 N=3 E=2 P=1 C=0).
//  Sub-module cpu_alu: combinational op1/op2/op -> {carry,result,next_flags}.
//  FSM, PC, IR, register file and handshake stay in the top.
// TESTING
//  1. Reset, then LD R1<-[0x010] with memory=0x0000_00FF, zero-wait.
//     -> R1=0xFF after 5 cycles; PSR unchanged.
//  2. Memory acks after 3 wait cycles.
//     -> mem_en, address and read_write are stable for all 4 cycles; IR latched only on ack.
//  3. ADD R1=0xFFFF_FFFF + imm 1.
//     -> R=0, Z=1, C=1, E=1; BRA cond 5 taken to 0x020; BRA cond 6 not taken, PC+1.
//  4. SHF left by 4 of 0xF000_0001 (op1=0x24).
//     -> R=0x0000_0010, C=1.
//     ROT right by 1 of 0x1 -> 0x8000_0000, N=1.
//  5. PC=0xFFF BRA never, then HLT.
//     -> PC wraps to 0x000; halted=1; mem_en stays 0; retired_cnt holds; reset clears everything.
//  6. Reset asserted while mem_en=1 awaiting ack.
//     -> mem_en=0 next cycle; fetch restarts at address 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared encodings for the multi-cycle CPU: opcodes, branch conditions, FSM states, PSR layout.
package cpu_pkg;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LD  = 4'h1, OP_STR = 4'h2, OP_BRA = 4'h3,
                         OP_XOR = 4'h4, OP_ADD = 4'h5, OP_ROT = 4'h6, OP_SHF = 4'h7,
                         OP_HLT = 4'h8, OP_CMP = 4'h9;

  localparam logic [3:0] BC_ALW = 4'd0, BC_P  = 4'd1, BC_E  = 4'd2, BC_C = 4'd3,
                         BC_N   = 4'd4, BC_Z  = 4'd5, BC_NC = 4'd6, BC_GT = 4'd7;

  localparam int PSR_Z = 4, PSR_N = 3, PSR_E = 2, PSR_P = 1, PSR_C = 0;

  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_t;

  function automatic logic writes_psr(input logic [3:0] op);
    return (op == OP_XOR) || (op == OP_ADD) || (op == OP_ROT) ||
           (op == OP_SHF) || (op == OP_CMP);
  endfunction

  function automatic logic writes_reg(input logic [3:0] op);
    return writes_psr(op) || (op == OP_LD);
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational ALU: XOR/ADD/CMP/SHF/ROT producing result, carry and {Z,N,E,P}.
module cpu_alu import cpu_pkg::*; #(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] op1,
  input  logic [DATA_W-1:0] op2,
  output logic              carry,
  output logic [DATA_W-1:0] result,
  output logic [3:0]        next_flags
);
  localparam int CW = $clog2(DATA_W);

  logic [CW-1:0]       cnt;
  logic                left;
  logic [DATA_W:0]     shl;
  logic [2*DATA_W-1:0] rotl, rotr;

  // op1 low bits are the shift count, the next bit picks direction
  assign cnt  = op1[CW-1:0];
  assign left = op1[CW];
  assign shl  = {1'b0, op2} << cnt;
  assign rotl = {op2, op2} << cnt;
  assign rotr = {op2, op2} >> cnt;

  always_comb begin
    carry  = 1'b0;
    result = '0;
    case (op)
      OP_XOR: result = op1 ^ op2;
      OP_ADD: {carry, result} = {1'b0, op1} + {1'b0, op2};
      OP_CMP: result = '0 - op1;
      OP_SHF: begin
        if (left) {carry, result} = shl;
        else      result = op2 >> cnt;
      end
      OP_ROT: result = left ? rotl[2*DATA_W-1:DATA_W] : rotr[DATA_W-1:0];
      default: ;
    endcase
  end

  assign next_flags = {result == '0, result[DATA_W-1], ~^result, ^result};

endmodule

// File: rtl/cpu_mc_param.sv
// Parametrised multi-cycle CPU with mem_en/mem_ack handshake, registered PSR and HALT.
// Define CPU_PERF_CNT_EN to add the retired_cnt instruction counter port.
module cpu_mc_param import cpu_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int NREG   = 16
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] data_out,
  output logic [ADDR_W-1:0] address,
  output logic              read_write,
  output logic              mem_en,
  output logic              halted,
  output logic [4:0]        psr
`ifdef CPU_PERF_CNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);
  localparam int RW = $clog2(NREG);

  state_t state, state_nxt;

  logic [ADDR_W-1:0] pc;
  logic [31:0]       ir;
  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] op1_q, op2_q, res_q, mdr;
  logic [4:0]        flags_q;

  logic [3:0]        op, cond;
  logic [RW-1:0]     rs, rd;
  logic [DATA_W-1:0] op1, op2, alu_res;
  logic [3:0]        alu_nf;
  logic              alu_c, ack, br_ok;

  assign op   = ir[31:28];
  assign cond = ir[27:24];
  assign rs   = ir[12 +: RW];
  assign rd   = ir[0 +: RW];
  assign op1  = ir[27] ? DATA_W'(ir[23:12]) : regs[rs];
  assign op2  = ir[26] ? '0 : regs[rd];
  // an ack only counts against an outstanding request
  assign ack  = mem_en & mem_ack;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op         (op),
    .op1        (op1_q),
    .op2        (op2_q),
    .carry      (alu_c),
    .result     (alu_res),
    .next_flags (alu_nf)
  );

  always_comb begin
    br_ok = 1'b0;
    case (cond)
      BC_ALW: br_ok = 1'b1;
      BC_P:   br_ok = psr[PSR_P];
      BC_E:   br_ok = psr[PSR_E];
      BC_C:   br_ok = psr[PSR_C];
      BC_N:   br_ok = psr[PSR_N];
      BC_Z:   br_ok = psr[PSR_Z];
      BC_NC:  br_ok = ~psr[PSR_C];
      BC_GT:  br_ok = ~psr[PSR_N] & ~psr[PSR_Z];
      default: br_ok = 1'b0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (reset) state <= S_FETCH;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_FETCH:  if (ack) state_nxt = S_DECODE;
      S_DECODE: state_nxt = S_EXEC;
      S_EXEC:   state_nxt = (op == OP_LD || op == OP_STR) ? S_MEM : S_WB;
      S_MEM:    if (ack) state_nxt = S_WB;
      S_WB:     state_nxt = (op == OP_HLT) ? S_HALT : S_FETCH;
      S_HALT:   state_nxt = S_HALT;
      default:  state_nxt = S_FETCH;
    endcase
  end

  // Requests are launched one state early (WB->FETCH, EXEC->MEM) so a
  // same-cycle ack costs no extra cycle; only the first fetch after reset
  // spends a cycle raising mem_en.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      pc         <= '0;
      ir         <= '0;
      psr        <= '0;
      mem_en     <= 1'b0;
      read_write <= 1'b0;
      address    <= '0;
      data_out   <= '0;
      halted     <= 1'b0;
      op1_q      <= '0;
      op2_q      <= '0;
      res_q      <= '0;
      mdr        <= '0;
      flags_q    <= '0;
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_FETCH: begin
          if (!mem_en) begin
            mem_en     <= 1'b1;
            address    <= pc;
            read_write <= 1'b0;
          end else if (mem_ack) begin
            ir     <= data_in[31:0];
            mem_en <= 1'b0;
          end
        end
        S_DECODE: begin
          op1_q <= op1;
          op2_q <= op2;
        end
        S_EXEC: begin
          res_q   <= alu_res;
          flags_q <= {alu_nf, alu_c};
          pc      <= (op == OP_BRA && br_ok) ? ir[ADDR_W-1:0] : pc + ADDR_W'(1);
          if (op == OP_LD) begin
            mem_en     <= 1'b1;
            read_write <= 1'b0;
            address    <= ir[12 +: ADDR_W];
          end else if (op == OP_STR) begin
            mem_en     <= 1'b1;
            read_write <= 1'b1;
            address    <= ir[ADDR_W-1:0];
            data_out   <= op1_q;
          end
        end
        S_MEM: begin
          if (mem_ack) begin
            mem_en <= 1'b0;
            if (!read_write) mdr <= data_in;
          end
        end
        S_WB: begin
          if (writes_reg(op)) regs[rd] <= (op == OP_LD) ? mdr : res_q;
          if (writes_psr(op)) psr <= flags_q;
          if (op == OP_HLT) begin
            halted <= 1'b1;
          end else begin
            mem_en     <= 1'b1;
            address    <= pc;
            read_write <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef CPU_PERF_CNT_EN
  always_ff @(posedge clk_in) begin
    if (reset)             retired_cnt <= '0;
    else if (state == S_WB) retired_cnt <= retired_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_mc_param.sv
// Directed bench for cpu_mc_param: memory model with wait states and a request log.
module tb_cpu_mc_param;
  import cpu_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset  = 1'b1;
  logic [31:0] data_in, data_out;
  logic        mem_ack, read_write, mem_en, halted;
  logic [11:0] address;
  logic [4:0]  psr;
`ifdef CPU_PERF_CNT_EN
  logic [31:0] retired_cnt;
`endif

  cpu_mc_param #(.DATA_W(32), .ADDR_W(12), .NREG(16)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .data_in    (data_in),
    .mem_ack    (mem_ack),
    .data_out   (data_out),
    .address    (address),
    .read_write (read_write),
    .mem_en     (mem_en),
    .halted     (halted),
    .psr        (psr)
`ifdef CPU_PERF_CNT_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [11:0] a;
    logic        rw;
    logic [31:0] d;
    logic [31:0] cyc;
    logic [4:0]  p;
    logic [7:0]  len;
  } ent_t;

  logic [31:0] mem [4096];
  ent_t        lg [$];
  int          wait_n = 0;
  logic        stray  = 1'b0;
  int          wcnt   = 0;
  int          cyc    = 0;
  int          stab_err = 0;
  logic        holding = 1'b0;
  logic [11:0] h_a;
  logic        h_rw;
  logic [31:0] h_d;
  int          pass = 0, total = 0;

  // junk on data_in outside an accepted read is an HLT word
  assign mem_ack = mem_en ? (wcnt == wait_n) : stray;
  assign data_in = (mem_en && mem_ack) ? mem[address] : 32'h8000_0000;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (reset || !mem_en || mem_ack) wcnt <= 0;
    else                             wcnt <= wcnt + 1;
    if (holding && (mem_en !== 1'b1 || address !== h_a || read_write !== h_rw ||
                    (h_rw && data_out !== h_d)))
      stab_err <= stab_err + 1;
    holding <= mem_en && !mem_ack && !reset;
    h_a  <= address;
    h_rw <= read_write;
    h_d  <= data_out;
    if (mem_en && mem_ack && !reset)
      lg.push_back('{address, read_write, data_out, 32'(cyc), psr, 8'(wcnt + 1)});
  end

  function automatic bit find(input int b, input logic [11:0] a, input logic rw, output ent_t e);
    e = '0;
    for (int i = b; i < lg.size(); i++)
      if (lg[i].a == a && lg[i].rw == rw) begin
        e = lg[i];
        return 1'b1;
      end
    return 1'b0;
  endfunction

  task automatic clr_mem();
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
  endtask

  task automatic do_reset();
    @(negedge clk_in);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
  endtask

  task automatic run_halt(input int budget, input string nm);
    int n = 0;
    while (halted !== 1'b1 && n < budget) begin
      @(negedge clk_in);
      n++;
    end
    total++;
    if (halted !== 1'b1) $display("FAIL %s halt: halted=%b after %0d cycles, want 1", nm, halted, budget);
    else pass++;
  endtask

  task automatic load_ld_str();
    clr_mem();
    mem[0]     = 32'h1001_0001;  // LD  R1 <- [0x010]
    mem[1]     = 32'h2000_1100;  // STR R1 -> [0x100]
    mem[2]     = 32'h8000_0000;  // HLT
    mem[12'h010] = 32'h0000_00FF;
  endtask

  task automatic test_reset();
    clr_mem();
    do_reset();
    total++; if (mem_en !== 1'b0) $display("FAIL reset mem_en: got %b want 0", mem_en); else pass++;
    total++; if (address !== 12'h0) $display("FAIL reset address: got %h want 000", address); else pass++;
    total++; if (read_write !== 1'b0 || data_out !== 32'h0)
      $display("FAIL reset rw/data_out: got %b/%h want 0/0", read_write, data_out); else pass++;
    total++; if (halted !== 1'b0 || psr !== 5'h0)
      $display("FAIL reset halted/psr: got %b/%h want 0/00", halted, psr); else pass++;
`ifdef CPU_PERF_CNT_EN
    total++; if (retired_cnt !== 32'h0) $display("FAIL reset retired: got %0d want 0", retired_cnt); else pass++;
`endif
  endtask

  task automatic test_ld();
    int   b;
    ent_t e;
    bit   f;
    load_ld_str();
    wait_n = 0;
    b = lg.size();
    do_reset();
    run_halt(100, "ld");
    total++;
    if (lg.size() < b + 5 || lg[b+1].a !== 12'h010 || lg[b+1].rw !== 1'b0)
      $display("FAIL ld read: entries=%0d addr=%h want read of 010", lg.size() - b, lg[b+1].a);
    else pass++;
    total++;
    if (lg.size() < b + 3 || lg[b+2].cyc - lg[b].cyc !== 32'd5)
      $display("FAIL ld latency: got %0d want 5", lg[b+2].cyc - lg[b].cyc);
    else pass++;
    f = find(b, 12'h100, 1'b1, e);
    total++; if (!f || e.d !== 32'hFF) $display("FAIL ld R1: found=%0d got %h want 000000ff", f, e.d); else pass++;
    total++; if (psr !== 5'h0) $display("FAIL ld psr: got %h want 00", psr); else pass++;
  endtask

  task automatic test_wait();
    int   b, bad;
    ent_t e;
    bit   f;
    load_ld_str();
    wait_n = 3;
    stray  = 1'b1;
    b = lg.size();
    bad = stab_err;
    do_reset();
    run_halt(200, "wait");
    total++; if (stab_err !== bad) $display("FAIL wait stable: got %0d violations want 0", stab_err - bad); else pass++;
    bad = 0;
    for (int i = b; i < lg.size(); i++) if (lg[i].len != 8'd4) bad++;
    total++;
    if (lg.size() != b + 5 || bad != 0)
      $display("FAIL wait len: entries=%0d bad=%0d want 5 entries all 4 cycles", lg.size() - b, bad);
    else pass++;
    total++;
    if (lg.size() < b + 3 || lg[b+2].cyc - lg[b].cyc !== 32'd11)
      $display("FAIL wait latency: got %0d want 11", lg[b+2].cyc - lg[b].cyc);
    else pass++;
    f = find(b, 12'h100, 1'b1, e);
    total++; if (!f || e.d !== 32'hFF) $display("FAIL wait R1: found=%0d got %h want 000000ff", f, e.d); else pass++;
    wait_n = 0;
    stray  = 1'b0;
  endtask

  task automatic test_add_bra();
    int   b;
    ent_t e;
    bit   f;
    clr_mem();
    mem[0]       = 32'h1001_0001;  // LD  R1 <- [0x010]
    mem[1]       = 32'h5800_1001;  // ADD R1 = R1 + 1
    mem[2]       = 32'h2000_1100;  // STR R1 -> [0x100]
    mem[3]       = 32'h3500_0020;  // BRA Z -> 0x020
    mem[4]       = 32'h8000_0000;
    mem[12'h010] = 32'hFFFF_FFFF;
    mem[12'h020] = 32'h3600_0030;  // BRA ~C -> 0x030
    mem[12'h021] = 32'h8000_0000;
    b = lg.size();
    do_reset();
    run_halt(100, "add");
    f = find(b, 12'h100, 1'b1, e);
    total++; if (!f || e.d !== 32'h0) $display("FAIL add result: found=%0d got %h want 0", f, e.d); else pass++;
    total++; if (psr !== 5'b10101) $display("FAIL add psr: got %b want 10101", psr); else pass++;
    total++;
    if (lg.size() < b + 4 || lg[b+3].cyc - lg[b+2].cyc !== 32'd4)
      $display("FAIL add latency: got %0d want 4", lg[b+3].cyc - lg[b+2].cyc);
    else pass++;
    total++;
    if (lg.size() != b + 8 || lg[b+6].a !== 12'h020)
      $display("FAIL bra z taken: entries=%0d addr=%h want 020", lg.size() - b, lg[b+6].a);
    else pass++;
    total++;
    if (lg.size() != b + 8 || lg[b+7].a !== 12'h021)
      $display("FAIL bra nc not taken: addr=%h want 021", lg[b+7].a);
    else pass++;
  endtask

  task automatic test_shift();
    int   b;
    ent_t e;
    bit   f;
    clr_mem();
    mem[0] = 32'h1001_1002;  // LD  R2 <- [0x011]
    mem[1] = 32'h7802_4002;  // SHF left 4 R2
    mem[2] = 32'h2000_2101;  // STR R2 -> [0x101]
    mem[3] = 32'h3300_0040;  // BRA C -> 0x040
    mem[4] = 32'h8000_0000;
    mem[12'h011] = 32'hF000_0001;
    mem[12'h012] = 32'h0000_0001;
    mem[12'h040] = 32'h1001_2003;  // LD  R3 <- [0x012]
    mem[12'h041] = 32'h6800_1003;  // ROT right 1 R3
    mem[12'h042] = 32'h2000_3102;
    mem[12'h043] = 32'h9800_1004;  // CMP R4 = -1
    mem[12'h044] = 32'h2000_4103;
    mem[12'h045] = 32'h48FF_F004;  // XOR R4 ^= 0xFFF
    mem[12'h046] = 32'h2000_4104;
    mem[12'h047] = 32'h8000_0000;
    b = lg.size();
    do_reset();
    run_halt(200, "shift");
    f = find(b, 12'h101, 1'b1, e);
    total++; if (!f || e.d !== 32'h10) $display("FAIL shf result: found=%0d got %h want 00000010", f, e.d); else pass++;
    f = find(b, 12'h003, 1'b0, e);
    total++; if (!f || e.p !== 5'b00011) $display("FAIL shf psr: found=%0d got %b want 00011", f, e.p); else pass++;
    f = find(b, 12'h040, 1'b0, e);
    total++; if (!f) $display("FAIL bra c: fetch of 040 found=%0d want 1", f); else pass++;
    f = find(b, 12'h102, 1'b1, e);
    total++; if (!f || e.d !== 32'h8000_0000) $display("FAIL rot result: found=%0d got %h want 80000000", f, e.d); else pass++;
    f = find(b, 12'h043, 1'b0, e);
    total++; if (!f || e.p !== 5'b01010) $display("FAIL rot psr: found=%0d got %b want 01010", f, e.p); else pass++;
    f = find(b, 12'h103, 1'b1, e);
    total++; if (!f || e.d !== 32'hFFFF_FFFF) $display("FAIL cmp result: found=%0d got %h want ffffffff", f, e.d); else pass++;
    f = find(b, 12'h104, 1'b1, e);
    total++; if (!f || e.d !== 32'hFFFF_F000) $display("FAIL xor result: found=%0d got %h want fffff000", f, e.d); else pass++;
    total++; if (psr !== 5'b01100) $display("FAIL xor psr: got %b want 01100", psr); else pass++;
  endtask

  task automatic test_wrap_halt();
    int   b, n, hi;
    ent_t e;
    bit   f;
    clr_mem();
    mem[0]       = 32'h3000_0FFF;  // BRA always -> 0xFFF
    mem[12'hFFF] = 32'h3800_0555;  // BRA never
    b = lg.size();
    do_reset();
    n = 0;
    f = 1'b0;
    while (!f && n < 50) begin
      @(negedge clk_in);
      n++;
      f = find(b, 12'hFFF, 1'b0, e);
    end
    total++; if (!f) $display("FAIL wrap reach fff: found=%0d want 1", f); else pass++;
    mem[0] = 32'h8000_0000;
    run_halt(100, "wrap");
    total++;
    if (lg.size() != b + 3 || lg[b+1].a !== 12'hFFF || lg[b+2].a !== 12'h000)
      $display("FAIL wrap pc: entries=%0d addr=%h want 3 entries ending at 000", lg.size() - b, lg[b+2].a);
    else pass++;
`ifdef CPU_PERF_CNT_EN
    total++; if (retired_cnt !== 32'd3) $display("FAIL retired halt: got %0d want 3", retired_cnt); else pass++;
`endif
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_in);
      if (mem_en !== 1'b0 || halted !== 1'b1) hi++;
    end
    total++; if (hi != 0) $display("FAIL halt hold: got %0d bad cycles want 0", hi); else pass++;
`ifdef CPU_PERF_CNT_EN
    total++; if (retired_cnt !== 32'd3) $display("FAIL retired hold: got %0d want 3", retired_cnt); else pass++;
`endif
    do_reset();
    total++; if (halted !== 1'b0 || mem_en !== 1'b0)
      $display("FAIL halt reset: halted/mem_en got %b/%b want 0/0", halted, mem_en); else pass++;
`ifdef CPU_PERF_CNT_EN
    total++; if (retired_cnt !== 32'd0) $display("FAIL retired reset: got %0d want 0", retired_cnt); else pass++;
`endif
  endtask

  task automatic test_reset_mid();
    int   b, n;
    ent_t e;
    bit   f;
    load_ld_str();
    wait_n = 0;
    do_reset();
    n = 0;
    while (!(mem_en === 1'b1 && address === 12'h010 && read_write === 1'b0) && n < 50) begin
      @(negedge clk_in);
      n++;
    end
    total++; if (n >= 50) $display("FAIL mid reach ld: got timeout want ld request"); else pass++;
    reset = 1'b1;  // ack is high this very cycle
    b = lg.size();
    @(negedge clk_in);
    total++; if (mem_en !== 1'b0 || address !== 12'h0)
      $display("FAIL mid reset: mem_en/address got %b/%h want 0/000", mem_en, address); else pass++;
    reset = 1'b0;
    run_halt(100, "mid");
    total++;
    if (lg.size() < b + 1 || lg[b].a !== 12'h000 || lg[b].rw !== 1'b0)
      $display("FAIL mid restart: addr=%h want fetch at 000", lg[b].a);
    else pass++;
    f = find(b, 12'h100, 1'b1, e);
    total++; if (!f || e.d !== 32'hFF) $display("FAIL mid R1: found=%0d got %h want 000000ff", f, e.d); else pass++;
  endtask

  initial begin
    test_reset();
    test_ld();
    test_wait();
    test_add_bra();
    test_shift();
    test_wrap_halt();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
